// File: rtl/comp_serial_lsb.sv
// Bit-serial magnitude comparator: scans A and B LSB-first, one bit per clock,
// letting each more significant differing bit override the running verdict.
module comp_serial_lsb #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             gin,
   input  logic             ein,
   input  logic             lin,
   output logic             busy,
   output logic             done,
   output logic             gout,
   output logic             eout,
   output logic             lout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   typedef enum logic [1:0] {V_EQ, V_GT, V_LT} verdict_t;

   state_t           state;
   verdict_t         verdict;
   verdict_t         verdict_nxt;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [CW-1:0]    cnt;

   // Inconsistent seeds collapse by priority: less, then greater, else equal.
   function automatic verdict_t seed_verdict(input logic [2:0] lge);
      casez (lge)
         3'b1??:  return V_LT;
         3'b01?:  return V_GT;
         default: return V_EQ;
      endcase
   endfunction

   function automatic verdict_t step_verdict(input verdict_t v, input logic abit,
                                             input logic bbit);
      if (abit && !bbit) return V_GT;
      if (!abit && bbit) return V_LT;
      return v;
   endfunction

   function automatic logic [2:0] encode(input verdict_t v);
      case (v)
         V_GT:    return 3'b100;
         V_LT:    return 3'b001;
         default: return 3'b010;
      endcase
   endfunction

   always_comb begin
      verdict_nxt = step_verdict(verdict, sa[0], sb[0]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         verdict <= V_EQ;
         busy    <= 1'b0;
         done    <= 1'b0;
         gout    <= 1'b0;
         eout    <= 1'b0;
         lout    <= 1'b0;
         sa      <= '0;
         sb      <= '0;
         cnt     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  sa      <= a;
                  sb      <= b;
                  cnt     <= '0;
                  verdict <= seed_verdict({lin, gin, ein});
                  busy    <= 1'b1;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               verdict <= verdict_nxt;
               sa      <= sa >> 1;
               sb      <= sb >> 1;
               // The last bit's verdict goes straight to the outputs.
               if (cnt == LAST) begin
                  {gout, eout, lout} <= encode(verdict_nxt);
                  done               <= 1'b1;
                  state              <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
